alu_cc: RTL and testbench

- 32-bit integer ALU for the SPARC V8 integer unit.
- Executes the 23 SPARC V8 arithmetic, logical and shift operations, selected by a 6-bit op3 code.
- Result is registered. Integer condition codes N, Z, V, C are registered and change only on "cc" operations.
- Sits between the register-file operand muxes and the writeback / PSR icc logic.

---
 rtl/alu_cc_if.sv | 31 +++
 rtl/alu_cc.sv | 122 ++++++++++++
 tb/tb_alu_cc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_cc_if.sv
// alu_cc_if: operand/result bundle between the operand muxes and the ALU.
//   op    - SPARC V8 op3 operation code
//   a, b  - rs1 operand and rs2/simm13 operand (already sign-extended)
//   Cin   - PSR icc.C, consumed only by the ADDX/SUBX family
//   res   - registered result
//   N/Z/V/C - registered integer condition codes
// master: the operand side (drives op/a/b/Cin, observes result and flags)
// slave : the ALU (consumes op/a/b/Cin, drives result and flags)
interface alu_cc_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic [WIDTH-1:0] res;
    logic             N;
    logic             Z;
    logic             V;
    logic             C;

    modport master (
        output op, a, b, Cin,
        input  res, N, Z, V, C
    );

    modport slave (
        input  op, a, b, Cin,
        output res, N, Z, V, C
    );
endinterface

// File: rtl/alu_cc.sv
// alu_cc: SPARC V8 integer ALU with registered result and icc flags.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears result and all flags
//   bus   - alu_cc_if slave: op/a/b/Cin in, res/N/Z/V/C out
// One operation per cycle, one-cycle latency. Flags change only on the
// cc forms (op[5:4] = 01) of listed operations; everything else holds them.
module alu_cc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_cc_if.slave  bus
);
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic             cin_eff;

    assign op    = bus.op;
    assign a     = bus.a;
    assign b     = bus.b;
    assign shamt = b[4:0];

    // op3 bit 3 marks the ADDX/SUBX forms; every other op sees carry-in 0.
    assign cin_eff = op[3] & bus.Cin;

    // One extra bit on the left captures carry-out (add) or borrow (sub).
    logic [WIDTH:0] add_full;
    logic [WIDTH:0] sub_full;
    logic           add_v;
    logic           sub_v;

    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
    assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_eff};
    assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] res_reg, res_next;
    logic             n_reg, n_next;
    logic             z_reg, z_next;
    logic             v_reg, v_next;
    logic             c_reg, c_next;
    logic             op_valid;
    logic             v_calc;
    logic             c_calc;

    always_comb begin
        res_next = '0;
        op_valid = 1'b0;
        v_calc   = 1'b0;
        c_calc   = 1'b0;
        n_next   = n_reg;
        z_next   = z_reg;
        v_next   = v_reg;
        c_next   = c_reg;

        unique case (op[5:4])
            2'b00, 2'b01: begin
                op_valid = 1'b1;
                case (op[3:0])
                    4'h0, 4'h8: begin
                        res_next = add_full[WIDTH-1:0];
                        v_calc   = add_v;
                        c_calc   = add_full[WIDTH];
                    end
                    4'h4, 4'hC: begin
                        res_next = sub_full[WIDTH-1:0];
                        v_calc   = sub_v;
                        c_calc   = sub_full[WIDTH];
                    end
                    4'h1:    res_next = a & b;
                    4'h2:    res_next = a | b;
                    4'h3:    res_next = a ^ b;
                    4'h5:    res_next = a & ~b;
                    4'h6:    res_next = a | ~b;
                    4'h7:    res_next = ~(a ^ b);
                    default: op_valid = 1'b0;
                endcase
            end
            2'b10: begin
                case (op[3:0])
                    4'h5:    res_next = a << shamt;
                    4'h6:    res_next = a >> shamt;
                    4'h7:    res_next = $signed(a) >>> shamt;
                    default: res_next = '0;
                endcase
            end
            default: res_next = '0;
        endcase

        // Unlisted codes in the cc range leave the flags alone.
        if (op_valid && (op[5:4] == 2'b01)) begin
            n_next = res_next[WIDTH-1];
            z_next = (res_next == '0);
            v_next = v_calc;
            c_next = c_calc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_reg <= '0;
            n_reg   <= 1'b0;
            z_reg   <= 1'b0;
            v_reg   <= 1'b0;
            c_reg   <= 1'b0;
        end else begin
            res_reg <= res_next;
            n_reg   <= n_next;
            z_reg   <= z_next;
            v_reg   <= v_next;
            c_reg   <= c_next;
        end
    end

    assign bus.res = res_reg;
    assign bus.N   = n_reg;
    assign bus.Z   = z_reg;
    assign bus.V   = v_reg;
    assign bus.C   = c_reg;
endmodule

// File: tb/tb_alu_cc.sv
// tb_alu_cc: table-driven check of alu_cc with a scoreboard queue.
// Inputs are driven on the falling edge and the expected result is queued;
// a monitor pops one entry 1 time unit after each rising edge and compares.
module tb_alu_cc;
    logic clk;
    logic reset;

    alu_cc_if #(.WIDTH(32)) bus ();

    alu_cc #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic [3:0]  nzvc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [3:0]  nzvc;
    } exp_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input int idx, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin,
                         input logic [31:0] res, input logic [3:0] nzvc);
        exp_t e;
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        bus.Cin = cin;
        e.idx   = idx;
        e.res   = res;
        e.nzvc  = nzvc;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: one expected entry per rising edge after a drive.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("[TB] txn %0d res=%h nzvc=%b (want res=%h nzvc=%b)",
                         e.idx, bus.res, {bus.N, bus.Z, bus.V, bus.C}, e.res, e.nzvc);
                check($sformatf("res[%0d]", e.idx), bus.res, e.res);
                check($sformatf("nzvc[%0d]", e.idx), {28'd0, bus.N, bus.Z, bus.V, bus.C},
                      {28'd0, e.nzvc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        bus.op  = '0;
        bus.a   = '0;
        bus.b   = '0;
        bus.Cin = 1'b0;

        //          op         a             b             cin   res           NZVC
        vecs[0]  = '{6'b010000, 32'h7fffffff, 32'h00000001, 1'b0, 32'h80000000, 4'b1010};
        vecs[1]  = '{6'b000000, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b1010};
        vecs[2]  = '{6'b010100, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0100};
        vecs[3]  = '{6'b010100, 32'h00000003, 32'h00000007, 1'b0, 32'hfffffffc, 4'b1001};
        vecs[4]  = '{6'b011000, 32'hffffffff, 32'h00000000, 1'b1, 32'h00000000, 4'b0101};
        vecs[5]  = '{6'b001100, 32'h0000000a, 32'h00000003, 1'b1, 32'h00000006, 4'b0101};
        vecs[6]  = '{6'b010101, 32'hffffffff, 32'h0000000f, 1'b0, 32'hfffffff0, 4'b1000};
        vecs[7]  = '{6'b000111, 32'h00000000, 32'h00000000, 1'b0, 32'hffffffff, 4'b1000};
        vecs[8]  = '{6'b100101, 32'h00000001, 32'h0000001f, 1'b0, 32'h80000000, 4'b1000};
        vecs[9]  = '{6'b100110, 32'hfffffff8, 32'h00000001, 1'b0, 32'h7ffffffc, 4'b1000};
        vecs[10] = '{6'b100111, 32'hfffffff8, 32'h00000001, 1'b0, 32'hfffffffc, 4'b1000};
        vecs[11] = '{6'b100111, 32'hfffffff8, 32'h00000021, 1'b0, 32'hfffffffc, 4'b1000};
        vecs[12] = '{6'b000000, 32'h00000001, 32'h00000002, 1'b1, 32'h00000003, 4'b1000};
        vecs[13] = '{6'b001001, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b1000};
        vecs[14] = '{6'b011001, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b1000};
        vecs[15] = '{6'b100101, 32'h12345678, 32'h00000020, 1'b0, 32'h12345678, 4'b1000};
        vecs[16] = '{6'b010000, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0111};
        vecs[17] = '{6'b011100, 32'h00000005, 32'h00000005, 1'b1, 32'hffffffff, 4'b1001};
        vecs[18] = '{6'b010010, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0100};
        vecs[19] = '{6'b010011, 32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 4'b1000};
        vecs[20] = '{6'b010110, 32'h00000000, 32'hffffffff, 1'b0, 32'h00000000, 4'b0100};
        vecs[21] = '{6'b010100, 32'h80000000, 32'h00000001, 1'b0, 32'h7fffffff, 4'b0010};
        vecs[22] = '{6'b010001, 32'hf0f0f0f0, 32'hff00ff00, 1'b0, 32'hf000f000, 4'b1000};
        vecs[23] = '{6'b100111, 32'h7ffffff0, 32'h00000004, 1'b0, 32'h07ffffff, 4'b1000};
        vecs[24] = '{6'b100110, 32'h80000000, 32'h0000001f, 1'b0, 32'h00000001, 4'b1000};

        #3;
        check("reset_res", bus.res, 32'h0);
        check("reset_nzvc", {28'd0, bus.N, bus.Z, bus.V, bus.C}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].nzvc);
        end

        // Asynchronous reset in the middle of a cycle, with res=5 and N set.
        @(negedge clk);
        drive(100, 6'b000000, 32'd2, 32'd3, 1'b0, 32'd5, 4'b1000);
        @(posedge clk);
        #2;
        check("pre_reset_res", bus.res, 32'd5);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_res", bus.res, 32'h0);
        check("async_reset_nzvc", {28'd0, bus.N, bus.Z, bus.V, bus.C}, 32'h0);
        bus.op = 6'b010000;
        bus.a  = 32'd1;
        bus.b  = 32'd1;
        @(posedge clk);
        #1;
        check("held_reset_res", bus.res, 32'h0);
        check("held_reset_nzvc", {28'd0, bus.N, bus.Z, bus.V, bus.C}, 32'h0);

        // Recovery from reset: flags start from zero again.
        @(negedge clk);
        reset = 1'b0;
        drive(101, 6'b010100, 32'd3, 32'd7, 1'b0, 32'hfffffffc, 4'b1001);
        @(negedge clk);
        drive(102, 6'b000000, 32'd1, 32'd1, 1'b1, 32'd2, 4'b1001);
        @(posedge clk);
        #2;
        check("scoreboard_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
